// File: rtl/if_fetch_unit_if.sv
// Instruction-fetch bundle: imem request/response bus, redirect and stall from
// downstream, and the registered IF/ID outputs handed to decode.
// master: the fetch unit. slave: memory/decode/trap environment.
interface if_fetch_unit_if;
  // Instruction memory bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Control from decode / trap logic
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  // IF/ID boundary
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        if_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  stall,
    output instruction,
    output pc,
    output if_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output stall,
    input  instruction,
    input  pc,
    input  if_valid
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to imem,
// buffers returned words in a prefetch FIFO and presents one instruction/pc pair
// per cycle to decode through a registered IF/ID boundary.
// Optional feature: define IF_FETCH_BYPASS_EN to let a response that arrives
// while the FIFO is empty and IF/ID is loadable skip the FIFO (one cycle less
// fetch-to-decode latency). Default build routes every word through the FIFO.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2  // power of two, >= 2
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  // Counters must hold 0..FIFO_DEPTH inclusive.
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  // One extra bit so the credit sum cannot overflow.
  localparam int unsigned CrW  = CntW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] RstPcAligned = {RESET_PC[31:2], 2'b00};

  // State
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_word_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0]     instr_q, instr_d;
  logic [31:0]     id_pc_q, id_pc_d;
  logic            valid_q, valid_d;

  // Per-cycle decode of the handshakes
  logic            redirect;
  logic [31:0]     target_pc;
  logic            resp_ok;
  logic            resp_keep;
  logic            id_load;
  logic            fifo_empty;
  logic            bypass;
  logic            pop;
  logic            push;
  logic [CrW-1:0]  credit;
  logic            req;
  logic            grant;

  // Low address bits of a redirect are discarded by design.
  logic            unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Handshake decode, credit check and FIFO read/write strobes.
  always_comb begin
    redirect   = bus.redirect_valid;
    target_pc  = {bus.redirect_pc[31:2], 2'b00};
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok    = bus.imem_rvalid && (out_q != '0);
    resp_keep  = resp_ok && (discard_q == '0);
    id_load    = !valid_q || !bus.stall;
    fifo_empty = (cnt_q == '0);
`ifdef IF_FETCH_BYPASS_EN
    bypass     = resp_keep && fifo_empty && id_load && !redirect;
`else
    bypass     = 1'b0;
`endif
    pop        = id_load && !fifo_empty && !redirect;
    push       = resp_keep && !bypass && !redirect;
    // Outstanding plus buffered words may never exceed the FIFO capacity, so a
    // returning word always has a slot.
    credit     = CrW'(out_q) + CrW'(cnt_q) - CrW'(pop);
    req        = !rst && !redirect && (credit < CrW'(FIFO_DEPTH));
    grant      = req && bus.imem_gnt;
  end

  // Next-state for fetch/response PCs and the outstanding/discard counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    discard_d  = discard_q;

    if (grant && !resp_ok) begin
      out_d = out_q + CntW'(1);
    end else if (!grant && resp_ok) begin
      out_d = out_q - CntW'(1);
    end

    if (resp_ok && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp_keep) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end

    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d  = out_d;
    end
  end

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Next-state for the IF/ID register; held whenever valid and stalled.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;

    if (redirect) begin
      valid_d = 1'b0;
    end else if (id_load) begin
      if (pop) begin
        valid_d = 1'b1;
        instr_d = fifo_word_q[rd_ptr_q];
        id_pc_d = fifo_pc_q[rd_ptr_q];
      end else if (bypass) begin
        valid_d = 1'b1;
        instr_d = bus.imem_rdata;
        id_pc_d = resp_pc_q;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RstPcAligned;
      resp_pc_q  <= RstPcAligned;
      out_q      <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      instr_q    <= Nop;
      id_pc_q    <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      valid_q    <= valid_d;
    end
  end

  // FIFO storage; contents are only meaningful below cnt_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_word_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instruction = instr_q;
  assign bus.pc          = id_pc_q;
  assign bus.if_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a bench-side imem responder plus an
// in-order model of the expected decode stream (pc strictly +4, word from the
// memory model, outputs frozen while stalled).
module tb_if_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;
`ifdef IF_FETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC   (RstPc),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_due = -1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          gnt_rand = 1'b0;
  bit          held_prev = 1'b0;
  logic [31:0] exp_pc = RstPc;
  logic [31:0] prev_pc, prev_ins;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the ID stream, play memory, record any grant.
  task automatic tick();
    int lat;
    int due;
    @(negedge clk);
    if (held_prev) begin
      chk("hold_valid", 32'(bus.if_valid), 32'd1);
      chk("hold_pc", bus.pc, prev_pc);
      chk("hold_ins", bus.instruction, prev_ins);
    end else if (bus.if_valid === 1'b1) begin
      chk("seq_pc", bus.pc, exp_pc);
      chk("seq_ins", bus.instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    held_prev = (bus.if_valid === 1'b1) && bus.stall && !bus.redirect_valid;
    prev_pc   = bus.pc;
    prev_ins  = bus.instruction;

    bus.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr[0]);
      pend_addr.delete(0);
      pend_due.delete(0);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    if (bus.imem_req === 1'b1 && bus.imem_gnt) begin
      lat = int'($urandom_range(lat_lo, lat_hi));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(due);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] first_addr;
    logic [31:0] start_pc;
    bit          got;
    int          i;

    rst                = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall          = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0100);
    chk("rst_ins", bus.instruction, 32'h0000_0013);
    chk("rst_pc", bus.pc, 32'h0000_0100);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    rst = 1'b0;

    // Sequential fetch, latency 1, gnt always 1
    tick();
    chk("first_req", 32'(last_req), 32'd1);
    chk("addr0", last_addr, 32'h0000_0100);
    tick();
    chk("addr1", last_addr, 32'h0000_0104);
    tick();
    chk("addr2", last_addr, 32'h0000_0108);
    chk("first_valid", 32'(bus.if_valid), 32'd1);
    chk("first_pc", bus.pc, Byp ? 32'h0000_0104 : 32'h0000_0100);
    chk("first_ins", bus.instruction, Byp ? 32'hFEFB_0104 : 32'hFEFF_0100);

    // Stall three cycles with 0x108 on the ID side
    for (i = 0; i < 20 && !(bus.if_valid === 1'b1 && bus.pc == 32'h108); i++) tick();
    chk("find_108", bus.pc, 32'h0000_0108);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", bus.pc, 32'h0000_0108);
      chk("stall_ins", bus.instruction, 32'hFEF7_0108);
      chk("stall_credit", 32'(pend_due.size() <= 2), 32'd1);
    end
    bus.stall = 1'b0;
    tick();
    chk("resume_pc", bus.pc, 32'h0000_010C);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("no_gap", 32'(bus.if_valid), 32'd1);
    end

    // Latency 3, redirect with two requests in flight
    lat_lo = 3;
    lat_hi = 3;
    for (i = 0; i < 20 && pend_due.size() != 2; i++) tick();
    chk("two_outstanding", 32'(pend_due.size()), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2003;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_noreq", 32'(last_req), 32'd0);
    chk("redir_valid0", 32'(bus.if_valid), 32'd0);
    exp_pc     = 32'h0000_2000;
    got        = 1'b0;
    first_addr = 32'hx;
    for (i = 0; i < 30 && bus.if_valid !== 1'b1; i++) begin
      tick();
      if (last_req === 1'b1 && !got) begin
        first_addr = last_addr;
        got        = 1'b1;
      end
    end
    chk("redir_first_addr", first_addr, 32'h0000_2000);
    chk("redir_pc", bus.pc, 32'h0000_2000);
    chk("redir_ins", bus.instruction, 32'hDFFF_2000);

    // Redirect coinciding with stall and a returning word, latency 1
    lat_lo = 1;
    lat_hi = 1;
    for (i = 0; i < 30 && !(bus.if_valid === 1'b1 && pend_due.size() > 0 &&
                            pend_due[0] == cyc); i++) tick();
    chk("find_busy", 32'(bus.if_valid), 32'd1);
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3000;
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    exp_pc = 32'h0000_3000;
    chk("rs_valid0", 32'(bus.if_valid), 32'd0);
    tick();
    chk("rs_req", 32'(last_req), 32'd1);
    chk("rs_addr", last_addr, 32'h0000_3000);
    tick();
    chk("rs_lat_n2", 32'(bus.if_valid), 32'(Byp));
    tick();
    chk("rs_lat_n3", 32'(bus.if_valid), 32'd1);
    chk("rs_pc", bus.pc, Byp ? 32'h0000_3004 : 32'h0000_3000);

    // Address wrap at the top of the 32-bit space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    for (i = 0; i < 20; i++) begin
      tick();
      if (last_req === 1'b1) break;
    end
    chk("wrap_a0", last_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_a1", last_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_a2", last_addr, 32'h0000_0000);
    for (i = 0; i < 20 && !(bus.if_valid === 1'b1 && bus.pc == 32'h0); i++) tick();
    chk("wrap_pc", bus.pc, 32'h0000_0000);
    chk("wrap_ins", bus.instruction, 32'hFFFF_0000);

    // Random grant, latency 1-4, occasional stall
    gnt_rand = 1'b1;
    lat_lo   = 1;
    lat_hi   = 4;
    start_pc = exp_pc;
    for (int k = 0; k < 200; k++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.stall = 1'b0;
    chk("rand_progress", 32'(((exp_pc - start_pc) >> 2) >= 32'd20), 32'd1);
    gnt_rand = 1'b0;
    lat_lo   = 1;
    lat_hi   = 1;

    // Reset mid-operation; in-flight responses are never returned
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    tick();
    chk("mrst_req", 32'(bus.imem_req), 32'd0);
    chk("mrst_addr", bus.imem_addr, 32'h0000_0100);
    chk("mrst_ins", bus.instruction, 32'h0000_0013);
    chk("mrst_pc", bus.pc, 32'h0000_0100);
    chk("mrst_valid", 32'(bus.if_valid), 32'd0);
    rst       = 1'b0;
    exp_pc    = RstPc;
    held_prev = 1'b0;
    tick();
    chk("mrst_first_req", 32'(last_req), 32'd1);
    chk("mrst_first_addr", last_addr, 32'h0000_0100);
    for (i = 0; i < 20 && bus.if_valid !== 1'b1; i++) tick();
    chk("mrst_pc_out", bus.pc, 32'h0000_0100);
    for (int k = 0; k < 5; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage directly upstream of the decode stage: owns the fetch PC, issues word requests to instruction memory, buffers returned words in a small prefetch FIFO, and presents one `instruction`/`pc` pair per cycle to decode through a registered IF/ID boundary. It accepts PC redirects from decode (taken branch) or trap logic (mtvec/mepc), squashes all in-flight and buffered fetches, and honours decode back-pressure.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 2: prefetch FIFO entries; power of two, ≥2; also the cap on outstanding plus buffered fetches.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] always 0.
- `imem_gnt` in 1: request accepted this cycle; an accepted request needs `imem_req`=1 in the same cycle.
- `imem_rvalid` in 1: read data valid; responses return in request order, ≥1 cycle after grant.
- `imem_rdata` in 32: returned instruction word.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored, forced to 0.
- `stall` in 1: decode cannot accept; IF/ID outputs hold.
- `instruction` out 32: instruction to decode.
- `pc` out 32: address of `instruction`.
- `if_valid` out 1: `instruction`/`pc` valid.

## Operation
- State: `fetch_pc`, `resp_pc`, `outstanding` counter (granted, not returned), `discard` counter, FIFO of {pc, word}, IF/ID register.
- Issue: `imem_req` = !`redirect_valid` && (`outstanding` + `fifo_count` − `pop`) < `FIFO_DEPTH`, where `pop` is this cycle's FIFO read. `imem_addr` = `fetch_pc`. Request may be withdrawn at any cycle (SRAM-style bus, no hold rule).
- Grant (`imem_req` && `imem_gnt`): `fetch_pc` += 4 (32-bit wrap, 32'hFFFF_FFFC → 0); `outstanding`++.
- Response: `outstanding`−−. If `discard`>0: word dropped, `discard`−−. Else push {`resp_pc`, `imem_rdata`}, `resp_pc` += 4. Grant and response in the same cycle leave `outstanding` unchanged.
- IF/ID load when `!if_valid || !stall`: FIFO non-empty → pop head, `if_valid`=1; empty → `if_valid`=0. When held (`if_valid && stall`), all three outputs stay stable.
- Redirect (highest priority, overrides `stall`): FIFO cleared; `if_valid`←0; `fetch_pc`,`resp_pc` ← `redirect_pc`&~3; `discard` ← `outstanding` after this cycle's response is accounted (response in redirect cycle is dropped); no request issued that cycle.
- Response with `outstanding`=0 is a protocol error: ignored, counters unchanged.
- FIFO full: credit rule guarantees no overflow; never drops valid data.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instruction`=32'h0000_0013 (NOP), `pc`=`RESET_PC`, `if_valid`=0, all counters 0. First `imem_req`=1 in cycle after `rst` deasserts.
- `rst` mid-operation: state returns to reset values next edge; later responses to pre-reset requests are not counted (bench must not return them).
- Redirect at cycle N, 1-cycle memory, `gnt`=1: request to target at N+1, `rvalid` at N+2; `if_valid`=1 with target at N+3 (bypass) or N+4 (no bypass).
- Throughput: 1 instruction/cycle sustained with `gnt`=1, 1-cycle latency, `FIFO_DEPTH`≥2, `stall`=0.

## Configuration
- `IF_FETCH_BYPASS_EN` defined: response arriving while FIFO empty and IF/ID loadable goes straight to IF/ID register (not pushed), saving one cycle.
- Undefined: every response passes through FIFO; one extra cycle fetch-to-decode latency; throughput unchanged.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, mem latency 1, `gnt`=1 → addrs 0x100,0x104,0x108…; `pc` on ID side 0x100,0x104… in consecutive cycles, no gaps.
- Assert `stall` 3 cycles while `if_valid`=1 at pc 0x108 → outputs hold pc 0x108 word; `outstanding`+`fifo_count` ≤ 2; resume at 0x10C with no loss/duplication.
- Latency 3, 2 outstanding, redirect to 0x0000_2003 → both stale responses dropped; next valid `pc`=0x0000_2000.
- Redirect same cycle as `stall`=1 and `rvalid`=1 → `if_valid`=0 next cycle; returned word never appears.
- `gnt` toggling 0/1 random, random latency 1-4 → ID `pc` sequence strictly +4, words match memory model.
- Fetch at 0xFFFF_FFF8 → next addrs 0xFFFF_FFFC, 0x0000_0000.
